// File: rtl/uart_rx_frame_if.sv
// Signal bundle between the UART frame receiver and its consumer.
// The receiver side uses the slave modport; the consumer/driver side uses master.
interface uart_rx_frame_if;
    logic       b_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;
    logic [2:0] state_dbg;

    // rx_done is a valid-only strobe with no ready: the consumer must take
    // rx_data, frame_err and parity_err in the single cycle rx_done is high.
    modport slave (
        input  b_tick,
        input  rx,
        output rx_data,
        output rx_done,
        output frame_err,
        output parity_err,
        output rx_busy,
        output state_dbg
    );

    modport master (
        output b_tick,
        output rx,
        input  rx_data,
        input  rx_done,
        input  frame_err,
        input  parity_err,
        input  rx_busy,
        input  state_dbg
    );
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampled UART frame receiver: start + 8 data (LSB first) [+ even parity] + stop.
// Define UART_RX_PARITY_EN to add the parity bit, PARITY state and parity_err logic.
module uart_rx_frame #(
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_frame_if.slave  bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_CNT = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          busy_q;
    logic          rx_meta, rx_s, rx_prev;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          perr_q, perr_d;
`endif

    // Synchronizer and edge history idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            busy_q    <= (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = perr_q;
`endif
        case (state_q)
            IDLE: begin
                tick_d  = '0;
                bit_d   = '0;
                shift_d = '0;
                // A line still low after a break has no falling edge, so it waits here.
                if (rx_prev && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (bus.b_tick) begin
                    if (tick_q == HALF_CNT) begin
                        tick_d  = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (bus.b_tick) begin
                    if (tick_q == LAST_CNT) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bus.b_tick) begin
                    if (tick_q == LAST_CNT) begin
                        tick_d    = '0;
                        par_bad_d = ^{shift_q, rx_s};
                        state_d   = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (bus.b_tick) begin
                    if (tick_q == LAST_CNT) begin
                        tick_d  = '0;
                        state_d = IDLE;
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_bad_q;
`endif
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_done    = done_q;
    assign bus.frame_err  = ferr_q;
    assign bus.rx_busy    = busy_q;
    assign bus.state_dbg  = state_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, b_tick pulses per bit period; legal values 8 or 16.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port b_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  8  last received byte.
REQ-007 SHALL have port rx_done  output  1  one-clk pulse, frame complete.
REQ-008 SHALL have port frame_err  output  1  stop bit sampled 0 on last frame.
REQ-009 SHALL have port parity_err  output  1  parity mismatch on last frame; constant 0 when parity is compiled out.
REQ-010 SHALL have port rx_busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when parity is compiled in.
REQ-013 IDLE: SHALL enter START when rx_s falls, i.e. previous rx_s = 1 and current rx_s = 0. Tick counter cleared; shift register cleared.
REQ-014 START: SHALL count b_tick. At count OVERSAMPLE/2-1:
  - rx_s = 0: SHALL clear the counter and enter DATA.
  - rx_s = 1: SHALL return to IDLE (glitch rejected) with no rx_done.
REQ-015 DATA: SHALL sample rx_s at tick count OVERSAMPLE-1 (bit centre) and shift it into bit 7 with a right shift, LSB first. After the 8th sample it SHALL enter PARITY, or STOP if parity is compiled out.
REQ-016 PARITY: SHALL sample at tick count OVERSAMPLE-1 and compare against even parity: the XOR of the 8 data bits and the parity bit must be 0.
REQ-017 STOP: SHALL sample at tick count OVERSAMPLE-1, then in the next clk:
  - load rx_data;
  - pulse rx_done for exactly 1 clk;
  - update frame_err (stop sample = 0) and parity_err;
  - return to IDLE.
REQ-018 frame_err and parity_err SHALL hold their value until the next rx_done.
REQ-019 rx_data SHALL change only in the rx_done cycle.
REQ-020 Latency SHALL be 1 clk from the stop-centre b_tick to rx_done, plus the 2-clk synchronizer delay.
REQ-021 Tick and bit counters SHALL advance only on b_tick and SHALL be cleared on every state transition; no wrap-around inside a state.
REQ-022 If rx_s is still 0 on return to IDLE after a frame error (break), a new frame SHALL NOT start until rx_s has been 1 for at least 1 clk.
REQ-023 rx changes without b_tick SHALL NOT advance state except the IDLE start detect.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 When rst = 0 at a clk edge, the block SHALL go to IDLE regardless of state, including mid-frame.
REQ-026 Reset values: rx_data = 0x00, rx_done = 0, frame_err = 0, parity_err = 0, rx_busy = 0. Counters are cleared and synchronizer flops are set to 1.
REQ-027 A frame interrupted by reset SHALL NOT produce rx_done.

Configuration
REQ-028 Macro UART_RX_PARITY_EN:
  - defined: frame is start + 8 data + 1 even parity + stop; PARITY state and parity_err logic present.
  - undefined: frame is start + 8 data + stop; PARITY state absent; parity_err tied to 0.

Verification
REQ-029 OVERSAMPLE = 16, parity compiled out, b_tick every 4 clk, send 0xA5 with valid stop -> one rx_done pulse, rx_data = 0xA5, frame_err = 0.
REQ-030 rx low for 4 b_ticks then high -> no rx_done, state back to IDLE, rx_busy = 0 within 8 b_ticks of the edge.
REQ-031 Send 0x3C with stop bit 0 -> rx_done, rx_data = 0x3C, frame_err = 1. Line then held low -> no new frame until rx returns high.
REQ-032 UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err = 1. Send 0x07 with parity bit 1 -> parity_err = 0.
REQ-033 Assert rst low during the 4th data bit of 0xFF -> outputs at reset values, no rx_done. Following frame 0x55 -> rx_data = 0x55.
REQ-034 Back-to-back 0x00 then 0xFF with no idle gap -> two rx_done pulses, rx_data 0x00 then 0xFF, frame_err = 0 both.
